linebuf_window_ctrl: RTL and testbench

//  Sequencer for the programmable-delay line-buffer FIFOs (one fifo_prg per kernel row) that feed
//  KxK neighbourhood filters in the camera pipeline. It counts the incoming pixel stream and

---
 rtl/linebuf_window_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_linebuf_window_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/linebuf_window_ctrl.sv
// rtl/linebuf_window_ctrl.sv - line-buffer FIFO sequencer with window coordinate generation
//
// Sequences the per-row line-buffer FIFOs of a KxK neighbourhood filter.
// The block counts the input pixel stream and programs the FIFO delay to the
// line width. After the last input pixel it flushes the FIFOs with padded
// pixels. It also reports which window centre sits at the FIFO outputs.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   cfg_width, cfg_height    frame geometry, sampled only on sof
//   sof                      start-of-frame pulse (no pixel on that cycle)
//   pix_valid                input pixel present
//   fifo_rst_n               synchronous reset to the line FIFOs
//   fifo_size                programmed FIFO delay (latched width)
//   fifo_enable              FIFO advance, combinational, aligned with input pixel
//   pix_pad                  selects zero data into the FIFOs during flush
//   win_valid                window centred on (out_x, out_y) at FIFO outputs
//   out_x, out_y             window centre coordinates
//   border                   centre within KERNEL/2 of an image edge
//   busy                     controller not idle
//   cfg_error                sticky: last sof rejected for bad geometry
//   frame_abort              pulse: active frame cut short by a new sof

module linebuf_window_ctrl #(
    parameter int KERNEL       = 3,
    parameter int ADDRESS_SIZE = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    input  logic        sof,
    input  logic        pix_valid,
    output logic        fifo_rst_n,
    output logic [15:0] fifo_size,
    output logic        fifo_enable,
    output logic        pix_pad,
    output logic        win_valid,
    output logic [15:0] out_x,
    output logic [15:0] out_y,
    output logic        border,
    output logic        busy,
    output logic        cfg_error,
    output logic        frame_abort
);

    localparam logic [31:0] C_H    = 32'(KERNEL / 2);
    localparam logic [16:0] C_H17  = 17'(KERNEL / 2);
    localparam logic [31:0] C_K    = 32'(KERNEL);
    localparam logic [31:0] C_MAXW = 32'(1) << ADDRESS_SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t      r_state;
    logic [15:0] r_w;
    logic [15:0] r_ht;
    logic [31:0] r_lat;
    logic [31:0] r_total;
    logic [31:0] r_in_cnt;
    logic [31:0] r_flush_cnt;
    logic [15:0] r_nx;          // centre of the next window to be produced
    logic [15:0] r_ny;
    logic        r_fifo_rst_n;
    logic [15:0] r_fifo_size;
    logic        r_win_valid;
    logic [15:0] r_out_x;
    logic [15:0] r_out_y;
    logic        r_border;
    logic        r_cfg_error;
    logic        r_frame_abort;

    logic w_active;
    logic w_cfg_ok;
    logic w_pix;
    logic w_flush;
    logic w_win_en;
    logic w_last_pix;
    logic w_flush_done;
    logic w_border;

    assign w_active = (r_state == S_FILL) || (r_state == S_RUN) || (r_state == S_FLUSH);

    assign w_cfg_ok = ({16'd0, cfg_width} >= C_K) && ({16'd0, cfg_width} <= C_MAXW) &&
                      ({16'd0, cfg_height} >= C_K);

    // sof never carries a pixel, so it masks both pixel and flush advances.
    assign w_pix   = !sof && pix_valid && ((r_state == S_FILL) || (r_state == S_RUN));
    assign w_flush = !sof && (r_state == S_FLUSH);

    // Pixels still filling the line buffers do not complete a window.
    assign w_win_en = (w_pix && (r_state == S_RUN)) || w_flush;

    assign w_last_pix   = w_pix && (r_in_cnt == r_total - 32'd1);
    assign w_flush_done = (r_flush_cnt == r_lat - 32'd1);

    // x > W-1-H is evaluated as x+H >= W to stay clear of unsigned underflow.
    assign w_border = ({1'b0, r_nx} < C_H17) || ({1'b0, r_nx} + C_H17 >= {1'b0, r_w}) ||
                      ({1'b0, r_ny} < C_H17) || ({1'b0, r_ny} + C_H17 >= {1'b0, r_ht});

    assign fifo_enable = reset_n && (w_pix || w_flush);
    assign pix_pad     = reset_n && w_flush;
    assign busy        = (r_state != S_IDLE);
    assign fifo_rst_n  = r_fifo_rst_n;
    assign fifo_size   = r_fifo_size;
    assign win_valid   = r_win_valid;
    assign out_x       = r_out_x;
    assign out_y       = r_out_y;
    assign border      = r_border;
    assign cfg_error   = r_cfg_error;
    assign frame_abort = r_frame_abort;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_w           <= 16'd0;
            r_ht          <= 16'd0;
            r_lat         <= 32'd0;
            r_total       <= 32'd0;
            r_in_cnt      <= 32'd0;
            r_flush_cnt   <= 32'd0;
            r_nx          <= 16'd0;
            r_ny          <= 16'd0;
            r_fifo_rst_n  <= 1'b0;
            r_fifo_size   <= 16'd0;
            r_win_valid   <= 1'b0;
            r_out_x       <= 16'd0;
            r_out_y       <= 16'd0;
            r_border      <= 1'b0;
            r_cfg_error   <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_fifo_rst_n  <= 1'b1;
            r_frame_abort <= 1'b0;
            r_win_valid   <= w_win_en;
            r_border      <= w_win_en && w_border;

            if (w_win_en) begin
                r_out_x <= r_nx;
                r_out_y <= r_ny;
                if (r_nx == r_w - 16'd1) begin
                    r_nx <= 16'd0;
                    r_ny <= r_ny + 16'd1;
                end else begin
                    r_nx <= r_nx + 16'd1;
                end
            end

            if (sof) begin
                r_frame_abort <= w_active;
                if (!w_cfg_ok) begin
                    r_cfg_error <= 1'b1;
                    r_state     <= S_IDLE;
                end else begin
                    r_cfg_error  <= 1'b0;
                    r_w          <= cfg_width;
                    r_ht         <= cfg_height;
                    r_fifo_size  <= cfg_width;
                    r_fifo_rst_n <= 1'b0;
                    r_state      <= S_PRIME;
                end
            end else begin
                case (r_state)
                    S_PRIME: begin
                        r_in_cnt    <= 32'd0;
                        r_flush_cnt <= 32'd0;
                        r_nx        <= 16'd0;
                        r_ny        <= 16'd0;
                        r_lat       <= C_H * {16'd0, r_w} + C_H;
                        r_total     <= {16'd0, r_w} * {16'd0, r_ht};
                        r_state     <= S_FILL;
                    end
                    S_FILL, S_RUN: begin
                        if (w_pix) begin
                            r_in_cnt <= r_in_cnt + 32'd1;
                            if (w_last_pix) begin
                                r_state <= S_FLUSH;
                            end else if ((r_state == S_FILL) && (r_in_cnt + 32'd1 == r_lat)) begin
                                r_state <= S_RUN;
                            end
                        end
                    end
                    S_FLUSH: begin
                        r_flush_cnt <= r_flush_cnt + 32'd1;
                        if (w_flush_done) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// tb/tb_linebuf_window_ctrl.sv - scoreboard bench for linebuf_window_ctrl

module tb_linebuf_window_ctrl;

    localparam int K = 3;
    localparam int H = K / 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cfg_width = 16'd0;
    logic [15:0] cfg_height = 16'd0;
    logic        sof = 1'b0;
    logic        pix_valid = 1'b0;
    logic        fifo_rst_n;
    logic [15:0] fifo_size;
    logic        fifo_enable;
    logic        pix_pad;
    logic        win_valid;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic        border;
    logic        busy;
    logic        cfg_error;
    logic        frame_abort;

    linebuf_window_ctrl #(.KERNEL(K), .ADDRESS_SIZE(12)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .sof(sof), .pix_valid(pix_valid), .fifo_rst_n(fifo_rst_n), .fifo_size(fifo_size),
        .fifo_enable(fifo_enable), .pix_pad(pix_pad), .win_valid(win_valid),
        .out_x(out_x), .out_y(out_y), .border(border), .busy(busy),
        .cfg_error(cfg_error), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int x;
        int y;
        bit b;
    } win_t;

    win_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   win_cnt = 0;
    int   pad_cnt = 0;
    int   en_cnt = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_win(int c, int idx, int w, int h);
        win_t e;
        e.cyc = c;
        e.x   = idx % w;
        e.y   = idx / w;
        e.b   = (e.x < H) || (e.x >= w - H) || (e.y < H) || (e.y >= h - H);
        sb.push_back(e);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a window.
    always @(negedge clk) begin
        if (mon_en) begin
            if (win_valid) begin
                win_cnt++;
                if (sb.size() == 0) begin
                    chk("win_unexpected", 32'd1, 32'd0);
                end else begin
                    win_t e;
                    e = sb.pop_front();
                    chk("win_cycle", 32'(cyc), 32'(e.cyc));
                    chk("win_x", 32'(out_x), 32'(e.x));
                    chk("win_y", 32'(out_y), 32'(e.y));
                    chk("win_border", 32'(border), 32'(e.b));
                end
            end else begin
                chk("border_idle", 32'(border), 32'd0);
            end
            if (pix_pad) pad_cnt++;
            if (fifo_enable) en_cnt++;
        end
    end

    task automatic send_sof(int w, int h, bit exp_abort);
        bit ok;
        ok = (w >= K) && (w <= 4096) && (h >= K);
        @(posedge clk); #1;
        cfg_width  = 16'(w);
        cfg_height = 16'(h);
        sof        = 1'b1;
        pix_valid  = 1'($urandom_range(0, 1));
        #1;
        chk("sof_no_enable", 32'(fifo_enable), 32'd0);
        @(posedge clk); #1;
        sof       = 1'b0;
        pix_valid = 1'($urandom_range(0, 1));
        chk("frame_abort", 32'(frame_abort), 32'(exp_abort));
        chk("cfg_error", 32'(cfg_error), 32'(!ok));
        if (ok) begin
            chk("prime_fifo_rst_n", 32'(fifo_rst_n), 32'd0);
            chk("prime_busy", 32'(busy), 32'd1);
            chk("fifo_size_sof", 32'(fifo_size), 32'(w));
        end else begin
            chk("rej_busy", 32'(busy), 32'd0);
            chk("rej_fifo_rst_n", 32'(fifo_rst_n), 32'd1);
        end
        chk("sb_empty_at_sof", 32'(sb.size()), 32'd0);
        win_cnt = 0;
        pad_cnt = 0;
        en_cnt  = 0;
    endtask

    // mode 0: continuous, 1: toggle 1,0, 2: random.  Stops after stop_at pixels.
    task automatic run_pixels(int w, int h, int mode, int stop_at);
        int n, lat, i, ph;
        bit v;
        n   = w * h;
        lat = H * w + H;
        i   = 0;
        ph  = 0;
        while (i < n && i < stop_at) begin
            @(posedge clk); #1;
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (ph == 0);
            else v = 1'($urandom_range(0, 1));
            ph = ph ^ 1;
            pix_valid = v;
            if (i == 0) begin
                chk("fill_fifo_rst_n", 32'(fifo_rst_n), 32'd1);
                chk("fill_frame_abort", 32'(frame_abort), 32'd0);
            end
            if (i == n / 2) begin
                cfg_width  = 16'(w * 2);
                cfg_height = 16'($urandom_range(0, 65535));
            end
            if (v) begin
                if (i >= lat) push_win(cyc + 1, i - lat, w, h);
                if (i == n - 1)
                    for (int k = 0; k < lat; k++) push_win(cyc + 2 + k, n - lat + k, w, h);
                i++;
            end
        end
    endtask

    task automatic finish_frame(int w, int h);
        int lat;
        lat = H * w + H;
        repeat (lat + 3) begin
            @(posedge clk); #1;
            pix_valid = 1'($urandom_range(0, 1));
        end
        pix_valid = 1'b0;
        @(posedge clk); #1;
        chk("frame_win_count", 32'(win_cnt), 32'(w * h));
        chk("frame_pad_count", 32'(pad_cnt), 32'(lat));
        chk("frame_en_count", 32'(en_cnt), 32'(w * h + lat));
        chk("frame_sb_empty", 32'(sb.size()), 32'd0);
        chk("frame_busy_end", 32'(busy), 32'd0);
        chk("frame_fifo_size_hold", 32'(fifo_size), 32'(w));
    endtask

    task automatic full_frame(int w, int h, int mode, bit exp_abort);
        send_sof(w, h, exp_abort);
        run_pixels(w, h, mode, w * h);
        finish_frame(w, h);
    endtask

    task automatic rejected(int w, int h);
        send_sof(w, h, 1'b0);
        repeat (20) begin
            @(posedge clk); #1;
            pix_valid = 1'($urandom_range(0, 1));
        end
        pix_valid = 1'b0;
        @(posedge clk); #1;
        chk("rej_en_count", 32'(en_cnt), 32'd0);
        chk("rej_win_count", 32'(win_cnt), 32'd0);
        chk("rej_busy_after", 32'(busy), 32'd0);
        chk("rej_cfg_error_sticky", 32'(cfg_error), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fifo_rst_n", 32'(fifo_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_win_valid", 32'(win_valid), 32'd0);
        chk("rst_fifo_enable", 32'(fifo_enable), 32'd0);
        chk("rst_pix_pad", 32'(pix_pad), 32'd0);
        chk("rst_fifo_size", 32'(fifo_size), 32'd0);
        chk("rst_out_xy", {out_x, out_y}, 32'd0);
        chk("rst_flags", {29'd0, border, cfg_error, frame_abort}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_fifo_rst_n", 32'(fifo_rst_n), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;

        full_frame(8, 4, 0, 1'b0);
        full_frame(8, 4, 1, 1'b0);

        rejected(2, 4);
        rejected(4097, 4);
        rejected(8, 2);
        full_frame(8, 4, 0, 1'b0);

        send_sof(8, 4, 1'b0);
        run_pixels(8, 4, 0, 20);
        full_frame(6, 5, 2, 1'b1);

        full_frame(8, 4, 2, 1'b0);
        full_frame(16, 3, 0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            full_frame(int'($urandom_range(3, 12)), int'($urandom_range(3, 6)),
                       int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
